axi_rd_responder: RTL and testbench
===================================

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte-address width; DATA_W, 64, R data width; MEM_DEPTH, 1024, number of DATA_W-bit words in backing store.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low; ports clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-003 AR channel ports SHALL be: araddr input ADDR_W byte address; arvalid input 1; arready output 1; arburst input 2 (00 FIXED, 01 INCR, 10 WRAP, 11 reserved); arsize input 3 (log2 bytes per beat); arlen input 8 (beats-1); arcache input 4 (accepted, ignored).
REQ-004 R channel ports SHALL be: rvalid output 1; rready input 1; rdata output DATA_W; rresp output 2 (00 OKAY, 10 SLVERR); rlast output 1.
REQ-005 Preload ports SHALL be: mem_we input 1 write strobe; mem_waddr input log2(MEM_DEPTH) word index; mem_wdata input DATA_W word.

Function
REQ-006 The FSM SHALL have two states: IDLE (arready=1, rvalid=0) and BURST (arready=0, rvalid=1).
REQ-007 IDLE->BURST SHALL occur on the clock edge where arvalid&&arready; araddr, arburst, arsize and arlen are captured on that edge, and the beat counter is cleared.
REQ-008 The first R beat SHALL be valid in the cycle after AR acceptance (1-cycle latency); AR acceptance and the first beat never share a cycle.
REQ-009 In BURST, rdata SHALL equal mem[cur_addr >> 3] combinationally from the registered current address; full 64-bit word returned regardless of arsize, and the initiator selects byte lanes.
REQ-010 rdata, rresp and rlast SHALL hold stable while rvalid && !rready.
REQ-011 On rvalid&&rready the address SHALL advance: FIXED keeps the address; INCR sets addr = (addr aligned down to 2^arsize) + 2^arsize; WRAP works like INCR but wraps within the aligned window of (arlen+1)*2^arsize bytes.
REQ-012 rlast SHALL be 1 exactly when beat counter == captured arlen.
REQ-013 On rvalid&&rready&&rlast the FSM SHALL return to IDLE, so arready=1 in the following cycle (one idle cycle between bursts).
REQ-014 rresp SHALL be SLVERR for every beat of a burst with arburst==11, arsize>3, or WRAP with arlen not in {1,3,7,15}; for these beats rdata=0 and the address does not advance.
REQ-015 A beat whose word index >= MEM_DEPTH SHALL return rdata=0 with rresp=SLVERR; the other beats of the same burst are unaffected.
REQ-016 INCR SHALL wrap modulo 2^ADDR_W with no 4 KB boundary check.
REQ-017 mem_we SHALL write mem[mem_waddr] on the clock edge in any state; a beat reading the same word in that cycle returns the old data, and the new data appears from the next cycle.
REQ-018 Max burst SHALL be 256 beats (arlen=255); the beat counter is 8 bits and does not overflow.

Reset
REQ-019 While rst_n=0 the block SHALL force state IDLE, rvalid=0, rlast=0, rresp=00, rdata=0, and beat counter 0; arready is 0 during reset and 1 from the first clock edge after deassertion.
REQ-020 Reset asserted mid-burst SHALL drop rvalid immediately (asynchronously) and discard the burst; memory contents SHALL be preserved (the array is not reset).

Structure
REQ-021 A shared package axi_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), the response codes (OKAY/SLVERR) and the DATA_W/ADDR_W defaults used by both the Core read initiator and this block.
REQ-022 Next-address computation SHALL live in one combinational sub-module axi_burst_addr (inputs addr, burst, size, len; output next_addr), reusable by the Core fetch path.

Verification
REQ-023 Preload mem[0..7]=0x1000+i; issue INCR araddr=0x0 arlen=3 arsize=3 with rready=1 -> four beats 0x1000..0x1003, rlast on beat 4 only, rresp=00, arready high the cycle after.
REQ-024 Issue WRAP araddr=0x18 arlen=3 arsize=3 -> beats from words 3,0,1,2 (0x1003,0x1000,0x1001,0x1002), rlast on 4th.
REQ-025 Issue INCR arlen=1 and hold rready=0 for 3 cycles -> rvalid stays 1 and rdata=0x1000 stays stable, then 2 beats complete normally.
REQ-026 Issue arburst=11 arlen=2 -> three beats, each rdata=0 and rresp=10, rlast on 3rd; then INCR araddr=(MEM_DEPTH-1)*8 arlen=1 -> beat1 OKAY, beat2 SLVERR with rdata=0.
REQ-027 Assert rst_n=0 during beat 2 of an arlen=7 burst -> rvalid=0 without waiting for a clock edge; after release arready=1 and mem[0]=0x1000 is still intact.
REQ-028 Drive mem_we to word 1 with 0xBEEF in the same cycle beat 2 (word 1) is presented with rready=0 -> old 0x1001 in that cycle, 0xBEEF from the next cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions.
// Holds the burst encodings, the response codes, the default bus widths, the
// responder FSM state type and the check for bursts that get SLVERR.
// Both the core read initiator and axi_rd_responder import this package.
package axi_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 64;

   typedef enum logic [1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10,
      BurstRsvd  = 2'b11
   } burst_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic {
      StIdle,
      StBurst
   } rd_state_e;

   // A burst is refused as a whole when its encoding is reserved, its beat
   // is wider than the 64-bit bus, or a WRAP length gives a window that is
   // not a power of two.
   function automatic logic burst_illegal(logic [1:0] burst, logic [2:0] size,
                                          logic [7:0] len);
      logic bad_wrap_len;
      bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      return (burst == BurstRsvd) || (size > 3'd3) || ((burst == BurstWrap) && bad_wrap_len);
   endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AR/R channel bundle between a read initiator and a read responder.
// Modports:
//   master - initiator: drives AR request fields and rready.
//   slave  - responder: drives arready and the R beat fields.
interface axi_rd_responder_if #(
   parameter int unsigned ADDR_W = axi_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = axi_pkg::DATA_W_DEF
);

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [1:0]        arburst;
   logic [2:0]        arsize;
   logic [7:0]        arlen;
   logic [3:0]        arcache;

   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output araddr, arvalid, arburst, arsize, arlen, arcache, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  araddr, arvalid, arburst, arsize, arlen, arcache, rready,
      output arready, rvalid, rdata, rresp, rlast
   );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address generator.
// Ports:
//   addr      - current beat byte address
//   burst     - FIXED / INCR / WRAP (reserved holds the address)
//   size      - log2 bytes per beat
//   len       - beats-1, sets the WRAP window
//   next_addr - byte address of the following beat
// INCR wraps modulo 2^ADDR_W; there is no 4 KB boundary handling.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        burst,
   input  logic [2:0]        size,
   input  logic [7:0]        len,
   output logic [ADDR_W-1:0] next_addr
);

   logic [ADDR_W-1:0] w_bytes;
   logic [ADDR_W-1:0] w_aligned;
   logic [ADDR_W-1:0] w_incr;
   logic [ADDR_W-1:0] w_wrap_mask;

   always_comb begin
      w_bytes     = ADDR_W'(1) << size;
      w_aligned   = addr & ~(w_bytes - ADDR_W'(1));
      w_incr      = w_aligned + w_bytes;
      // Window is (len+1) beats; only meaningful for power-of-two lengths.
      w_wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         BurstIncr: next_addr = w_incr;
         BurstWrap: next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
         default:   next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read responder backed by a preloadable word memory.
// Accepts one AR request at a time and returns its beats on R with a
// one-cycle first-beat latency.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   bus                    - AR/R channels (slave modport)
//   mem_we/waddr/wdata     - backdoor preload, one word per clock
// Error beats (illegal burst, or word index beyond MEM_DEPTH) carry SLVERR
// with zero data. The memory array itself is never reset.
module axi_rd_responder
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MEM_DEPTH = 1024
) (
   input logic                         clk,
   input logic                         rst_n,
   axi_rd_responder_if.slave           bus,
   input logic                         mem_we,
   input logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
   input logic [DATA_W-1:0]            mem_wdata
);

   localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
   localparam int unsigned WORD_W = ADDR_W - 3;

   rd_state_e         r_state;
   rd_state_e         w_state_nxt;
   logic              r_armed;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_burst;
   logic [2:0]        r_size;
   logic [7:0]        r_len;
   logic [7:0]        r_beat;
   logic              r_err;
   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   logic              w_ar_hs;
   logic              w_r_hs;
   logic              w_last;
   logic              w_oor;
   logic [WORD_W-1:0] w_word_idx;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_unused_arcache;

   assign w_ar_hs          = bus.arvalid && bus.arready;
   assign w_r_hs           = bus.rvalid && bus.rready;
   assign w_last           = (r_beat == r_len);
   assign w_word_idx       = r_addr[ADDR_W-1:3];
   assign w_oor            = (w_word_idx >= WORD_W'(MEM_DEPTH));
   assign w_unused_arcache = ^bus.arcache;

   axi_burst_addr #(
      .ADDR_W (ADDR_W)
   ) u_burst_addr (
      .addr      (r_addr),
      .burst     (r_burst),
      .size      (r_size),
      .len       (r_len),
      .next_addr (w_next_addr)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_ar_hs) w_state_nxt = StBurst;
         StBurst: if (w_r_hs && w_last) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Outputs. Everything is gated by state, so an async reset clears the R
   // channel immediately.
   always_comb begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rresp   = RespOkay;
      bus.rlast   = 1'b0;
      case (r_state)
         StIdle: bus.arready = r_armed;
         StBurst: begin
            bus.rvalid = 1'b1;
            bus.rlast  = w_last;
            if (r_err || w_oor) begin
               bus.rresp = RespSlverr;
            end else begin
               bus.rdata = r_mem[w_word_idx[MEM_AW-1:0]];
            end
         end
         default: ;
      endcase
   end

   // Burst context. r_armed keeps arready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_addr  <= '0;
         r_burst <= BurstFixed;
         r_size  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (w_ar_hs) begin
            r_addr  <= bus.araddr;
            r_burst <= bus.arburst;
            r_size  <= bus.arsize;
            r_len   <= bus.arlen;
            r_beat  <= '0;
            r_err   <= burst_illegal(bus.arburst, bus.arsize, bus.arlen);
         end else if (w_r_hs) begin
            // Counter stops at arlen, so 256-beat bursts never overflow.
            if (!w_last) r_beat <= r_beat + 8'd1;
            if (!r_err) r_addr <= w_next_addr;
         end
      end
   end

   // Backing store: a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (mem_we) r_mem[mem_waddr] <= mem_wdata;
   end

endmodule

// File: tb/tb_axi_rd_responder.sv
module tb_axi_rd_responder;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned MEM_DEPTH = 1024;

   logic        clk;
   logic        rst_n;
   logic        mem_we;
   logic [9:0]  mem_waddr;
   logic [63:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   axi_rd_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_rd_responder #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_issue(input string tag, input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] len);
      chk({tag, " arready before AR"}, 64'(bus.arready), 64'd1);
      bus.araddr  = addr;
      bus.arburst = burst;
      bus.arsize  = size;
      bus.arlen   = len;
      bus.arcache = 4'hA;
      bus.arvalid = 1'b1;
      chk({tag, " no rvalid with AR"}, 64'(bus.rvalid), 64'd0);
      step();
      bus.arvalid = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [63:0] data, input logic [1:0] resp,
                       input logic last);
      chk({tag, " rvalid"}, 64'(bus.rvalid), 64'd1);
      chk({tag, " rdata"}, bus.rdata, data);
      chk({tag, " rresp"}, 64'(bus.rresp), 64'(resp));
      chk({tag, " rlast"}, 64'(bus.rlast), 64'(last));
      chk({tag, " arready low"}, 64'(bus.arready), 64'd0);
      step();
   endtask

   task automatic idle_after(input string tag);
      chk({tag, " arready after"}, 64'(bus.arready), 64'd1);
      chk({tag, " rvalid after"}, 64'(bus.rvalid), 64'd0);
   endtask

   task automatic preload(input logic [9:0] a, input logic [63:0] d);
      mem_we    = 1'b1;
      mem_waddr = a;
      mem_wdata = d;
      step();
      mem_we    = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = '0;
      mem_wdata   = '0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.arburst = 2'b01;
      bus.arsize  = 3'd3;
      bus.arlen   = '0;
      bus.arcache = '0;
      bus.rready  = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("rst arready", 64'(bus.arready), 64'd0);
      chk("rst rvalid", 64'(bus.rvalid), 64'd0);
      chk("rst rlast", 64'(bus.rlast), 64'd0);
      chk("rst rresp", 64'(bus.rresp), 64'd0);
      chk("rst rdata", bus.rdata, 64'd0);
      #2 rst_n = 1'b1;
      step();
      chk("arready after release", 64'(bus.arready), 64'd1);

      for (int i = 0; i < 8; i++) preload(10'(i), 64'h1000 + 64'(i));
      preload(10'd1023, 64'hDEAD);

      // INCR 4 beats.
      bus.rready = 1'b1;
      ar_issue("incr4", 32'h0, 2'b01, 3'd3, 8'd3);
      beat("incr4 b1", 64'h1000, 2'b00, 1'b0);
      beat("incr4 b2", 64'h1001, 2'b00, 1'b0);
      beat("incr4 b3", 64'h1002, 2'b00, 1'b0);
      beat("incr4 b4", 64'h1003, 2'b00, 1'b1);
      idle_after("incr4");

      // WRAP 4 beats starting mid-window.
      ar_issue("wrap4", 32'h18, 2'b10, 3'd3, 8'd3);
      beat("wrap4 b1", 64'h1003, 2'b00, 1'b0);
      beat("wrap4 b2", 64'h1000, 2'b00, 1'b0);
      beat("wrap4 b3", 64'h1001, 2'b00, 1'b0);
      beat("wrap4 b4", 64'h1002, 2'b00, 1'b1);
      idle_after("wrap4");

      // Backpressure holds the beat stable.
      bus.rready = 1'b0;
      ar_issue("stall", 32'h0, 2'b01, 3'd3, 8'd1);
      for (int i = 0; i < 3; i++) begin
         chk("stall rvalid", 64'(bus.rvalid), 64'd1);
         chk("stall rdata", bus.rdata, 64'h1000);
         chk("stall rlast", 64'(bus.rlast), 64'd0);
         step();
      end
      bus.rready = 1'b1;
      beat("stall b1", 64'h1000, 2'b00, 1'b0);
      beat("stall b2", 64'h1001, 2'b00, 1'b1);
      idle_after("stall");

      // Reserved burst type: every beat is an error.
      ar_issue("rsvd", 32'h0, 2'b11, 3'd3, 8'd2);
      beat("rsvd b1", 64'h0, 2'b10, 1'b0);
      beat("rsvd b2", 64'h0, 2'b10, 1'b0);
      beat("rsvd b3", 64'h0, 2'b10, 1'b1);
      idle_after("rsvd");

      // Illegal WRAP length.
      ar_issue("wrap len2", 32'h8, 2'b10, 3'd3, 8'd2);
      beat("wrap len2 b1", 64'h0, 2'b10, 1'b0);
      beat("wrap len2 b2", 64'h0, 2'b10, 1'b0);
      beat("wrap len2 b3", 64'h0, 2'b10, 1'b1);

      // Running off the end of memory.
      ar_issue("oor", 32'((MEM_DEPTH - 1) * 8), 2'b01, 3'd3, 8'd1);
      beat("oor b1", 64'hDEAD, 2'b00, 1'b0);
      beat("oor b2", 64'h0, 2'b10, 1'b1);
      idle_after("oor");

      // Narrow INCR: 4-byte beats, second beat crosses into word 1.
      ar_issue("narrow", 32'h4, 2'b01, 3'd2, 8'd1);
      beat("narrow b1", 64'h1000, 2'b00, 1'b0);
      beat("narrow b2", 64'h1001, 2'b00, 1'b1);

      // FIXED keeps the address.
      ar_issue("fixed", 32'h10, 2'b00, 3'd3, 8'd1);
      beat("fixed b1", 64'h1002, 2'b00, 1'b0);
      beat("fixed b2", 64'h1002, 2'b00, 1'b1);

      // Write hitting the word being presented.
      ar_issue("wr", 32'h0, 2'b01, 3'd3, 8'd3);
      beat("wr b1", 64'h1000, 2'b00, 1'b0);
      bus.rready = 1'b0;
      mem_we     = 1'b1;
      mem_waddr  = 10'd1;
      mem_wdata  = 64'hBEEF;
      chk("wr old data", bus.rdata, 64'h1001);
      step();
      mem_we     = 1'b0;
      chk("wr new data", bus.rdata, 64'hBEEF);
      bus.rready = 1'b1;
      beat("wr b2", 64'hBEEF, 2'b00, 1'b0);
      beat("wr b3", 64'h1002, 2'b00, 1'b0);
      beat("wr b4", 64'h1003, 2'b00, 1'b1);

      // Asynchronous reset during beat 2 of an 8-beat burst.
      ar_issue("rst mid", 32'h0, 2'b01, 3'd3, 8'd7);
      beat("rst mid b1", 64'h1000, 2'b00, 1'b0);
      chk("rst mid b2 rvalid", 64'(bus.rvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mid rvalid async", 64'(bus.rvalid), 64'd0);
      chk("rst mid rlast async", 64'(bus.rlast), 64'd0);
      chk("rst mid arready", 64'(bus.arready), 64'd0);
      step();
      #2 rst_n = 1'b1;
      step();
      idle_after("rst mid");
      ar_issue("post rst", 32'h0, 2'b00, 3'd3, 8'd0);
      beat("post rst mem0", 64'h1000, 2'b00, 1'b1);
      idle_after("post rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
